gen_demux_9_1_collect: RTL and testbench
========================================

// Module: gen_demux_9_1_collect
// PURPOSE
//  Receive side of the 1-of-9 register-select path. Accepts a serial stream of
//  samples, each tagged with a 4-bit register number (0..8), and scatters each
//  sample into a 9-entry window bank. Presents the full 3x3 window once all 9
//  entries are written, with valid/ready handshakes on both sides.
//  Sits downstream of the mux1_9 select generator, ahead of the window-compute stage.
// PARAMETERS
//  DW     8   sample width in bits
//  CNT_W  16  width of the delivered-window counter
// PORTS
//  SYS_CLK        in   1      system clock; all logic on rising edge
//  SYS_NRST       in   1      synchronous reset, active-low
//  IN_VALID       in   1      IN_DATA/IN_REGNUM_SEL valid
//  IN_READY       out  1      block can accept a beat
//  IN_DATA        in   DW     sample
//  IN_REGNUM_SEL  in   4      target register number, legal 0..8
//  WIN_VALID      out  1      WIN_DATA holds a complete window
//  WIN_READY      in   1      downstream accepts the window
//  WIN_DATA       out  9*DW   entry k at WIN_DATA[k*DW +: DW]
//  WIN_CNT        out  CNT_W  windows delivered, wraps modulo 2^CNT_W
//  ERR_SEL        out  1      sticky: illegal, duplicate or out-of-order select
// BEHAVIOUR
//  Reset (SYS_NRST=0 at edge): state=COLLECT, mask=0, bank=0, WIN_VALID=0,
//   WIN_CNT=0, ERR_SEL=0, expected index=0. Reset overrides everything,
//   including a partly collected window or a pending WIN_VALID.
//  Two states:
//   COLLECT: IN_READY=1, WIN_VALID=0.
//   HOLD: IN_READY=0, WIN_VALID=1.
//  Beat accept = IN_VALID & IN_READY.
//  Legal beat (sel<=8) in COLLECT:
//   bank[sel] <= IN_DATA and mask[sel] <= 1 on the same edge.
//   If mask|onehot(sel) == 9'h1FF, go to HOLD on that edge.
//  Latency: WIN_VALID is high in the cycle after the 9th distinct entry is
//   accepted, so a window takes at least 9 accept cycles + 1.
//  Illegal beat (sel 9..15): consumed (handshake completes), data dropped,
//   mask unchanged, ERR_SEL <= 1.
//  Duplicate beat (mask[sel] already set): bank[sel] is overwritten with the
//   new data, mask unchanged, ERR_SEL <= 1.
//  HOLD: WIN_DATA is stable while WIN_VALID & !WIN_READY.
//   WIN_VALID & WIN_READY:
//    - mask <= 0, WIN_CNT <= WIN_CNT+1 (wraps), return to COLLECT.
//    - bank is not cleared; new beats overwrite it entry by entry.
//   Input is stalled in HOLD: there is always one bubble cycle between
//   window handoff and the first accept of the next window.
//  ERR_SEL: once set, stays set until reset. It never blocks operation.
//  IN_VALID is ignored in HOLD. IN_* need not be held stable while IN_READY=0.
// CONFIGURATION
//  GEN_DEMUX_9_1_SEQCHK_EN
//   defined: strict order check. A 4-bit expected index starts at 0.
//    - sel == expected: accepted as a legal beat, expected increments;
//      after 8 it goes back to 0 on window handoff.
//    - sel != expected (including illegal values): beat consumed and dropped,
//      ERR_SEL <= 1, expected unchanged. Duplicates cannot occur.
//   undefined: any order is accepted. Illegal and duplicate rules apply as above.
// TESTING
//  T1 reset: hold SYS_NRST=0 for 2 cycles, then release
//     -> IN_READY=1, WIN_VALID=0, WIN_CNT=0, ERR_SEL=0, WIN_DATA=0.
//  T2 in-order fill: sels 0..8 with data 8'h10..8'h18, one beat per cycle, WIN_READY=0
//     -> WIN_VALID=1 the cycle after beat 8; WIN_DATA[k*8+:8]=8'h10+k;
//        IN_READY=0; data held.
//  T3 handoff: from T2, pulse WIN_READY=1 for one cycle
//     -> WIN_CNT=1, WIN_VALID=0, IN_READY=1 next cycle; a beat offered in the
//        handoff cycle is not accepted.
//  T4 shuffled order (macro off): sels 8,3,0,5,1,7,2,6,4 -> full window,
//     ERR_SEL=0. Then a new window with sel 2 sent twice (8'hAA then 8'hBB)
//     -> entry 2 = 8'hBB, ERR_SEL=1, still needs the other 8 entries.
//  T5 illegal select: send sel=4'd12 with IN_VALID=1
//     -> IN_READY stays 1, mask unchanged, ERR_SEL=1; the following 9 legal
//        beats still complete a window.
//  T6 macro on: sels 0,1,3 -> sel 3 dropped, ERR_SEL=1; then 2..8
//     -> window completes with entry 3 from the second sel-3 beat.
//  T7 reset mid-window: reset after 5 beats
//     -> mask cleared; a full 9 beats are needed again.
//  T8 wrap (CNT_W=2): deliver 5 windows -> WIN_CNT sequence 1,2,3,0,1.

Source files
------------

// File: rtl/gen_demux_9_1_collect.sv
// ----------------------------------------------------------------------------
// gen_demux_9_1_collect
//
// Receive side of the 1-of-9 register-select path. Serial samples arrive, each
// tagged with a register number 0..8, and are scattered into a 9-entry window
// bank. When all 9 entries have been written the bank is presented as a 3x3
// window and held until downstream takes it.
//
// Ports
//   SYS_CLK        in   1      system clock, rising edge
//   SYS_NRST       in   1      synchronous reset, active-low
//   IN_VALID       in   1      IN_DATA / IN_REGNUM_SEL valid
//   IN_READY       out  1      block can accept a beat (high while collecting)
//   IN_DATA        in   DW     sample
//   IN_REGNUM_SEL  in   4      target register number, legal 0..8
//   WIN_VALID      out  1      WIN_DATA holds a complete window
//   WIN_READY      in   1      downstream accepts the window
//   WIN_DATA       out  9*DW   entry k at WIN_DATA[k*DW +: DW]
//   WIN_CNT        out  CNT_W  windows delivered, wraps
//   ERR_SEL        out  1      sticky: illegal, duplicate or out-of-order select
//
// Build option
//   GEN_DEMUX_9_1_SEQCHK_EN  when defined, selects must arrive strictly in
//                            order 0..8; any other select is consumed, dropped
//                            and flagged. When undefined, any order is taken.
// ----------------------------------------------------------------------------
module gen_demux_9_1_collect #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic              SYS_CLK,
  input  logic              SYS_NRST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DW-1:0]     IN_DATA,
  input  logic [3:0]        IN_REGNUM_SEL,
  output logic              WIN_VALID,
  input  logic              WIN_READY,
  output logic [9*DW-1:0]   WIN_DATA,
  output logic [CNT_W-1:0]  WIN_CNT,
  output logic              ERR_SEL
);

  localparam int unsigned NumRegs = 9;
  localparam logic [NumRegs-1:0] FullMask = 9'h1FF;

  localparam logic [0:0] StCollect = 1'b0;
  localparam logic [0:0] StHold    = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NumRegs-1:0] mask_q, mask_d;
  logic [DW-1:0]      bank_q [NumRegs];
  logic [DW-1:0]      bank_d [NumRegs];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               accept;
  logic               sel_legal;
  logic               take;
  logic               dup;
  logic [NumRegs-1:0] sel_onehot;

  // Decode the select; illegal values (9..15) give an all-zero vector.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned k = 0; k < NumRegs; k++) begin
      if (IN_REGNUM_SEL == 4'(k)) begin
        sel_onehot[k] = 1'b1;
      end
    end
  end

  assign sel_legal = (IN_REGNUM_SEL <= 4'd8);
  assign accept    = IN_VALID & IN_READY;
  assign dup       = |(mask_q & sel_onehot);

`ifdef GEN_DEMUX_9_1_SEQCHK_EN
  // Index of the next register the strict-order checker will take.
  logic [3:0] exp_q, exp_d;

  assign take = accept & sel_legal & (IN_REGNUM_SEL == exp_q);

  always_comb begin
    exp_d = exp_q;
    if (take) begin
      exp_d = exp_q + 4'd1;
    end else if ((state_q == StHold) && WIN_READY) begin
      exp_d = 4'd0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_NRST) begin
      exp_q <= 4'd0;
    end else begin
      exp_q <= exp_d;
    end
  end
`else
  assign take = accept & sel_legal;
`endif

  // Any consumed beat that is not taken is an error, as is overwriting an
  // entry already filled in the current window. Neither stalls the stream.
  assign err_d = err_q | (accept & ~take) | (take & dup);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StCollect: begin
        if (take) begin
          for (int unsigned k = 0; k < NumRegs; k++) begin
            if (sel_onehot[k]) begin
              bank_d[k] = IN_DATA;
            end
          end
          mask_d = mask_q | sel_onehot;
          if (mask_d == FullMask) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // Bank is left as-is; the next window overwrites it entry by entry.
        if (WIN_READY) begin
          mask_d  = '0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StCollect;
        end
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_NRST) begin
      state_q <= StCollect;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < NumRegs; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int unsigned k = 0; k < NumRegs; k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  assign IN_READY  = (state_q == StCollect);
  assign WIN_VALID = (state_q == StHold);
  assign WIN_CNT   = cnt_q;
  assign ERR_SEL   = err_q;

  always_comb begin
    WIN_DATA = '0;
    for (int unsigned k = 0; k < NumRegs; k++) begin
      WIN_DATA[k*DW +: DW] = bank_q[k];
    end
  end

  // Handshake sanity.
  a_one_side: assert property (@(posedge SYS_CLK) disable iff (!SYS_NRST)
    !(IN_READY && WIN_VALID));
  a_hold_stable: assert property (@(posedge SYS_CLK) disable iff (!SYS_NRST)
    (WIN_VALID && !WIN_READY) |=> (WIN_VALID && $stable(WIN_DATA)));

endmodule

// File: tb/tb_gen_demux_9_1_collect.sv
module tb_gen_demux_9_1_collect;

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 2;

  logic              SYS_CLK = 1'b0;
  logic              SYS_NRST;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DW-1:0]     IN_DATA;
  logic [3:0]        IN_REGNUM_SEL;
  logic              WIN_VALID;
  logic              WIN_READY;
  logic [9*DW-1:0]   WIN_DATA;
  logic [CNT_W-1:0]  WIN_CNT;
  logic              ERR_SEL;

  gen_demux_9_1_collect #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .SYS_CLK       (SYS_CLK),
    .SYS_NRST      (SYS_NRST),
    .IN_VALID      (IN_VALID),
    .IN_READY      (IN_READY),
    .IN_DATA       (IN_DATA),
    .IN_REGNUM_SEL (IN_REGNUM_SEL),
    .WIN_VALID     (WIN_VALID),
    .WIN_READY     (WIN_READY),
    .WIN_DATA      (WIN_DATA),
    .WIN_CNT       (WIN_CNT),
    .ERR_SEL       (ERR_SEL)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [71:0] data;
    logic [1:0]  cnt;
  } win_t;

  win_t exp_q[$];
  win_t mon_w;
  int   n_checks = 0;
  int   n_err    = 0;

  // Select orders, first select in the lowest nibble.
  localparam logic [35:0] SelsInOrder = 36'h876543210;
  localparam logic [35:0] SelsShuffle = 36'h462715038; // 8,3,0,5,1,7,2,6,4
  localparam logic [35:0] SelsRotated = 36'h432108765; // 5,6,7,8,0,1,2,3,4

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: inputs change at posedge+1, so at negedge the
  // handshake about to happen on the next rising edge is visible.
  always @(negedge SYS_CLK) begin
    if (SYS_NRST === 1'b1 && WIN_VALID === 1'b1 && WIN_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL win_unexpected: got window %0h, expected none", WIN_DATA);
      end else begin
        mon_w = exp_q.pop_front();
        chk("win_data", WIN_DATA, mon_w.data);
        chk("win_cnt_at_handoff", 72'(WIN_CNT), 72'(mon_w.cnt));
      end
    end
  end

  function automatic logic [71:0] mkwin(input logic [7:0] base);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[k*8 +: 8] = 8'(base + 8'(k));
    end
    return w;
  endfunction

  task automatic push_win(input logic [71:0] d, input logic [1:0] c);
    win_t w;
    w.data = d;
    w.cnt  = c;
    exp_q.push_back(w);
  endtask

  // All tasks start and end at posedge+1.
  task automatic drive_beat(input logic [3:0] sel, input logic [7:0] d);
    IN_VALID      = 1'b1;
    IN_REGNUM_SEL = sel;
    IN_DATA       = d;
    @(posedge SYS_CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic send_seq(input logic [35:0] sels, input int first, input int last,
                          input logic [7:0] base);
    logic [3:0] s;
    for (int i = first; i <= last; i++) begin
      s = sels[i*4 +: 4];
      drive_beat(s, 8'(base + 8'(s)));
    end
  endtask

  task automatic handoff(input logic [1:0] cnt_after, input string name);
    WIN_READY = 1'b1;
    @(posedge SYS_CLK);
    #1;
    WIN_READY = 1'b0;
    chk({name, "_cnt"}, 72'(WIN_CNT), 72'(cnt_after));
    chk({name, "_valid_low"}, 72'(WIN_VALID), 72'd0);
    chk({name, "_ready_high"}, 72'(IN_READY), 72'd1);
  endtask

  task automatic do_reset();
    SYS_NRST  = 1'b0;
    IN_VALID  = 1'b0;
    WIN_READY = 1'b0;
    repeat (2) @(posedge SYS_CLK);
    #1;
    SYS_NRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    IN_DATA       = '0;
    IN_REGNUM_SEL = '0;
    IN_VALID      = 1'b0;
    WIN_READY     = 1'b0;

    // T1 reset
    do_reset();
    chk("rst_in_ready", 72'(IN_READY), 72'd1);
    chk("rst_win_valid", 72'(WIN_VALID), 72'd0);
    chk("rst_win_cnt", 72'(WIN_CNT), 72'd0);
    chk("rst_err", 72'(ERR_SEL), 72'd0);
    chk("rst_win_data", WIN_DATA, 72'd0);

    // T2 in-order fill
    push_win(72'h181716151413121110, 2'd0);
    send_seq(SelsInOrder, 0, 7, 8'h10);
    chk("t2_valid_after_8", 72'(WIN_VALID), 72'd0);
    send_seq(SelsInOrder, 8, 8, 8'h10);
    chk("t2_valid", 72'(WIN_VALID), 72'd1);
    chk("t2_in_ready_low", 72'(IN_READY), 72'd0);
    chk("t2_data", WIN_DATA, 72'h181716151413121110);
    @(posedge SYS_CLK);
    #1;
    chk("t2_data_held", WIN_DATA, 72'h181716151413121110);
    chk("t2_valid_held", 72'(WIN_VALID), 72'd1);

    // T3 handoff with a beat offered in the same cycle (must not be taken)
    IN_VALID      = 1'b1;
    IN_REGNUM_SEL = 4'd0;
    IN_DATA       = 8'hEE;
    handoff(2'd1, "t3");
    IN_VALID = 1'b0;
    chk("t3_bank_kept", 72'(WIN_DATA[7:0]), 72'h10);

    // T4a: shuffled order (strict build uses in-order), no error expected
    push_win(mkwin(8'h30), 2'd1);
`ifdef GEN_DEMUX_9_1_SEQCHK_EN
    send_seq(SelsInOrder, 0, 8, 8'h30);
`else
    send_seq(SelsShuffle, 0, 8, 8'h30);
`endif
    chk("t4_valid", 72'(WIN_VALID), 72'd1);
    chk("t4_err_clear", 72'(ERR_SEL), 72'd0);
    handoff(2'd2, "t4");

    // T5 illegal select
    IN_VALID      = 1'b1;
    IN_REGNUM_SEL = 4'd12;
    IN_DATA       = 8'hFF;
    chk("t5_ready_offered", 72'(IN_READY), 72'd1);
    @(posedge SYS_CLK);
    #1;
    IN_VALID = 1'b0;
    chk("t5_ready_after", 72'(IN_READY), 72'd1);
    chk("t5_err", 72'(ERR_SEL), 72'd1);
    push_win(mkwin(8'h60), 2'd2);
    send_seq(SelsInOrder, 0, 7, 8'h60);
    chk("t5_valid_after_8", 72'(WIN_VALID), 72'd0);
    send_seq(SelsInOrder, 8, 8, 8'h60);
    chk("t5_valid", 72'(WIN_VALID), 72'd1);
    handoff(2'd3, "t5");

    // T7 reset mid-window
    send_seq(SelsInOrder, 0, 4, 8'h70);
    do_reset();
    chk("t7_data_cleared", WIN_DATA, 72'd0);
    chk("t7_err_cleared", 72'(ERR_SEL), 72'd0);
    chk("t7_cnt_cleared", 72'(WIN_CNT), 72'd0);
    push_win(mkwin(8'h80), 2'd0);
`ifdef GEN_DEMUX_9_1_SEQCHK_EN
    send_seq(SelsInOrder, 0, 7, 8'h80);
    chk("t7_valid_after_8", 72'(WIN_VALID), 72'd0);
    send_seq(SelsInOrder, 8, 8, 8'h80);
`else
    send_seq(SelsRotated, 0, 7, 8'h80);
    chk("t7_valid_after_8", 72'(WIN_VALID), 72'd0);
    send_seq(SelsRotated, 8, 8, 8'h80);
`endif
    chk("t7_valid", 72'(WIN_VALID), 72'd1);
    handoff(2'd1, "t8_w1");

`ifdef GEN_DEMUX_9_1_SEQCHK_EN
    // T6 out-of-order select dropped
    drive_beat(4'd0, 8'h50);
    drive_beat(4'd1, 8'h51);
    drive_beat(4'd3, 8'h77);
    chk("t6_err", 72'(ERR_SEL), 72'd1);
    chk("t6_valid_low", 72'(WIN_VALID), 72'd0);
    push_win(mkwin(8'h50), 2'd1);
    send_seq(SelsInOrder, 2, 8, 8'h50);
    chk("t6_valid", 72'(WIN_VALID), 72'd1);
`else
    // T4b duplicate select: second write wins
    drive_beat(4'd2, 8'hAA);
    chk("t4b_err_first", 72'(ERR_SEL), 72'd0);
    drive_beat(4'd2, 8'hBB);
    chk("t4b_err_dup", 72'(ERR_SEL), 72'd1);
    push_win(72'h484746454443BB4140, 2'd1);
    drive_beat(4'd0, 8'h40);
    drive_beat(4'd1, 8'h41);
    send_seq(SelsInOrder, 3, 7, 8'h40);
    chk("t4b_valid_without_8", 72'(WIN_VALID), 72'd0);
    send_seq(SelsInOrder, 8, 8, 8'h40);
    chk("t4b_valid", 72'(WIN_VALID), 72'd1);
`endif
    handoff(2'd2, "t8_w2");

    // T8 counter wrap: 3, 0, 1
    push_win(mkwin(8'h90), 2'd2);
    send_seq(SelsInOrder, 0, 8, 8'h90);
    handoff(2'd3, "t8_w3");
    push_win(mkwin(8'hA0), 2'd3);
    send_seq(SelsInOrder, 0, 8, 8'hA0);
    handoff(2'd0, "t8_w4");
    push_win(mkwin(8'hB0), 2'd0);
    send_seq(SelsInOrder, 0, 8, 8'hB0);
    handoff(2'd1, "t8_w5");

    repeat (2) @(posedge SYS_CLK);
    #1;
    chk("scoreboard_drained", 72'(exp_q.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
